// File: rtl/core_pkg.sv
// Shared RV32I core types: the decoded instruction record, opcode/funct constants and ALU op codes.
// Configuration macro RV32M_EN enables the single-cycle multiply subset of the M extension.
package core_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        lui;
      logic        auipc;
      logic        jal;
      logic        jalr;
      logic        branch;
      logic        load;
      logic        store;
      logic        op_imm;
      logic        op;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        illegal;
   } instructions;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef RV32M_EN
   localparam logic M_EXT = 1'b1;
`else
   localparam logic M_EXT = 1'b0;
`endif

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
   } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32 ALU used by the execute half; multiply ops exist only when RV32M_EN is defined.
module alu
   import core_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o
);

   logic [4:0] shamt;
   assign shamt = b_i[4:0];

`ifdef RV32M_EN
   // Sign-extend to 64 bits as the op requires; the low 64 bits of the product are then exact.
   logic [63:0] ma;
   logic [63:0] mb;
   logic [63:0] prod;
   logic        a_signed;
   logic        b_signed;
   assign a_signed = (op_i == ALU_MULH) || (op_i == ALU_MULHSU);
   assign b_signed = (op_i == ALU_MULH);
   assign ma   = {{32{a_signed & a_i[31]}}, a_i};
   assign mb   = {{32{b_signed & b_i[31]}}, b_i};
   assign prod = ma * mb;
`endif

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:    result_o = a_i + b_i;
         ALU_SUB:    result_o = a_i - b_i;
         ALU_SLL:    result_o = a_i << shamt;
         ALU_SLT:    result_o = {31'b0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU:   result_o = {31'b0, a_i < b_i};
         ALU_XOR:    result_o = a_i ^ b_i;
         ALU_SRL:    result_o = a_i >> shamt;
         ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
         ALU_OR:     result_o = a_i | b_i;
         ALU_AND:    result_o = a_i & b_i;
`ifdef RV32M_EN
         ALU_MUL:    result_o = prod[31:0];
         ALU_MULH:   result_o = prod[63:32];
         ALU_MULHSU: result_o = prod[63:32];
         ALU_MULHU:  result_o = prod[63:32];
`endif
         default:    result_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_execute.sv
// Decode and execute halves of the multi-cycle RV32I core, each with a one-shot enable and sticky completed flag.
// Configuration macro RV32M_EN (see core_pkg) enables MUL/MULH/MULHSU/MULHU.
module decode_execute
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        dec_enabled,
   input  logic [31:0] dec_pc,
   input  logic [31:0] dec_instr_raw,
   output logic        dec_completed,
   output instructions dec_instr,
   output logic [4:0]  dec_rs1,
   output logic [4:0]  dec_rs2,
   input  logic        exe_enabled,
   input  instructions exe_instr,
   input  logic [31:0] exe_rs1,
   input  logic [31:0] exe_rs2,
   output logic        exe_completed,
   output instructions exe_instr_out,
   output logic [31:0] exe_rs1_out,
   output logic [31:0] exe_rs2_out,
   output logic [31:0] exe_rd,
   output logic        exe_br_taken,
   output logic [31:0] exe_jump_dest
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   instructions dec_d, dec_q;
   logic        dec_completed_q;

   assign opcode = dec_instr_raw[6:0];
   assign f3     = dec_instr_raw[14:12];
   assign f7     = dec_instr_raw[31:25];
   assign imm_i  = {{20{dec_instr_raw[31]}}, dec_instr_raw[31:20]};
   assign imm_s  = {{20{dec_instr_raw[31]}}, dec_instr_raw[31:25], dec_instr_raw[11:7]};
   assign imm_b  = {{19{dec_instr_raw[31]}}, dec_instr_raw[31], dec_instr_raw[7],
                    dec_instr_raw[30:25], dec_instr_raw[11:8], 1'b0};
   assign imm_u  = {dec_instr_raw[31:12], 12'b0};
   assign imm_j  = {{11{dec_instr_raw[31]}}, dec_instr_raw[31], dec_instr_raw[19:12],
                    dec_instr_raw[20], dec_instr_raw[30:21], 1'b0};

   always_comb begin
      dec_d        = '0;
      dec_d.rd     = dec_instr_raw[11:7];
      dec_d.rs1    = dec_instr_raw[19:15];
      dec_d.rs2    = dec_instr_raw[24:20];
      dec_d.pc     = dec_pc;
      dec_d.funct3 = f3;
      dec_d.funct7 = f7;
      case (opcode)
         OPC_LUI:    begin dec_d.lui   = 1'b1; dec_d.imm = imm_u; end
         OPC_AUIPC:  begin dec_d.auipc = 1'b1; dec_d.imm = imm_u; end
         OPC_JAL:    begin dec_d.jal   = 1'b1; dec_d.imm = imm_j; end
         OPC_JALR: begin
            dec_d.jalr    = 1'b1;
            dec_d.imm     = imm_i;
            dec_d.illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec_d.branch  = 1'b1;
            dec_d.imm     = imm_b;
            dec_d.illegal = (f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            dec_d.load    = 1'b1;
            dec_d.imm     = imm_i;
            dec_d.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            dec_d.store   = 1'b1;
            dec_d.imm     = imm_s;
            dec_d.illegal = f3[2] || (f3 == 3'b011);
         end
         OPC_OP_IMM: begin
            // Immediate shifts reuse the funct7 field, so it must hold a valid shift encoding.
            dec_d.op_imm = 1'b1;
            dec_d.imm    = imm_i;
            if (f3 == F3_SLL)
               dec_d.illegal = (f7 != F7_BASE);
            else if (f3 == F3_SRL)
               dec_d.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
         end
         OPC_OP: begin
            dec_d.op = 1'b1;
            case (f7)
               F7_BASE:   dec_d.illegal = 1'b0;
               F7_ALT:    dec_d.illegal = !((f3 == F3_ADD) || (f3 == F3_SRL));
               F7_MULDIV: dec_d.illegal = !M_EXT || f3[2];
               default:   dec_d.illegal = 1'b1;
            endcase
         end
         default: dec_d.illegal = 1'b1;
      endcase
   end

   alu_op_e     alu_op;
   logic [31:0] alu_b, alu_res, pc_plus_imm, pc_plus_4, jalr_sum;
   logic        br_cond;
   logic [31:0] exe_rd_d, exe_dest_d;
   logic        exe_taken_d;
   instructions exe_instr_q;
   logic [31:0] exe_rs1_q, exe_rs2_q, exe_rd_q, exe_dest_q;
   logic        exe_taken_q, exe_completed_q;

   always_comb begin
      alu_op = ALU_ADD;
      case (exe_instr.funct3)
         F3_ADD:  alu_op = (exe_instr.op && exe_instr.funct7[5]) ? ALU_SUB : ALU_ADD;
         F3_SLL:  alu_op = ALU_SLL;
         F3_SLT:  alu_op = ALU_SLT;
         F3_SLTU: alu_op = ALU_SLTU;
         F3_XOR:  alu_op = ALU_XOR;
         F3_SRL:  alu_op = (exe_instr.op ? exe_instr.funct7[5] : exe_instr.imm[10]) ? ALU_SRA : ALU_SRL;
         F3_OR:   alu_op = ALU_OR;
         F3_AND:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
`ifdef RV32M_EN
      if (exe_instr.op && (exe_instr.funct7 == F7_MULDIV)) begin
         case (exe_instr.funct3[1:0])
            2'b00:   alu_op = ALU_MUL;
            2'b01:   alu_op = ALU_MULH;
            2'b10:   alu_op = ALU_MULHSU;
            default: alu_op = ALU_MULHU;
         endcase
      end
`endif
   end

   assign alu_b = exe_instr.op ? exe_rs2 : exe_instr.imm;

   alu u_alu (
      .op_i     (alu_op),
      .a_i      (exe_rs1),
      .b_i      (alu_b),
      .result_o (alu_res)
   );

   assign pc_plus_imm = exe_instr.pc + exe_instr.imm;
   assign pc_plus_4   = exe_instr.pc + 32'd4;
   assign jalr_sum    = exe_rs1 + exe_instr.imm;

   always_comb begin
      br_cond = 1'b0;
      case (exe_instr.funct3)
         F3_BEQ:  br_cond = (exe_rs1 == exe_rs2);
         F3_BNE:  br_cond = (exe_rs1 != exe_rs2);
         F3_BLT:  br_cond = ($signed(exe_rs1) < $signed(exe_rs2));
         F3_BGE:  br_cond = ($signed(exe_rs1) >= $signed(exe_rs2));
         F3_BLTU: br_cond = (exe_rs1 < exe_rs2);
         F3_BGEU: br_cond = (exe_rs1 >= exe_rs2);
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      exe_rd_d    = '0;
      exe_taken_d = 1'b0;
      exe_dest_d  = '0;
      if (exe_instr.illegal) begin
         exe_rd_d = '0;
      end else if (exe_instr.lui) begin
         exe_rd_d = exe_instr.imm;
      end else if (exe_instr.auipc) begin
         exe_rd_d = pc_plus_imm;
      end else if (exe_instr.jal) begin
         exe_rd_d    = pc_plus_4;
         exe_taken_d = 1'b1;
         exe_dest_d  = pc_plus_imm;
      end else if (exe_instr.jalr) begin
         exe_rd_d    = pc_plus_4;
         exe_taken_d = 1'b1;
         exe_dest_d  = {jalr_sum[31:1], 1'b0};
      end else if (exe_instr.branch) begin
         exe_taken_d = br_cond;
         exe_dest_d  = pc_plus_imm;
      end else if (exe_instr.load || exe_instr.store) begin
         exe_rd_d = jalr_sum;
      end else if (exe_instr.op || exe_instr.op_imm) begin
         exe_rd_d = alu_res;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dec_q           <= '0;
         dec_completed_q <= 1'b0;
         exe_instr_q     <= '0;
         exe_rs1_q       <= '0;
         exe_rs2_q       <= '0;
         exe_rd_q        <= '0;
         exe_dest_q      <= '0;
         exe_taken_q     <= 1'b0;
         exe_completed_q <= 1'b0;
      end else begin
         if (dec_enabled) begin
            dec_q           <= dec_d;
            dec_completed_q <= 1'b1;
         end
         if (exe_enabled) begin
            exe_instr_q     <= exe_instr;
            exe_rs1_q       <= exe_rs1;
            exe_rs2_q       <= exe_rs2;
            exe_rd_q        <= exe_rd_d;
            exe_dest_q      <= exe_dest_d;
            exe_taken_q     <= exe_taken_d;
            exe_completed_q <= 1'b1;
         end
      end
   end

   assign dec_completed = dec_completed_q;
   assign dec_instr     = dec_q;
   assign dec_rs1       = dec_q.rs1;
   assign dec_rs2       = dec_q.rs2;
   assign exe_completed = exe_completed_q;
   assign exe_instr_out = exe_instr_q;
   assign exe_rs1_out   = exe_rs1_q;
   assign exe_rs2_out   = exe_rs2_q;
   assign exe_rd        = exe_rd_q;
   assign exe_br_taken  = exe_taken_q;
   assign exe_jump_dest = exe_dest_q;

endmodule

// File: tb/tb_decode_execute.sv
// Scoreboard bench for decode_execute: drivers queue hand-computed expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_decode_execute;
   import core_pkg::*;

   localparam logic [8:0] C_LUI    = 9'b1_0000_0000;
   localparam logic [8:0] C_AUIPC  = 9'b0_1000_0000;
   localparam logic [8:0] C_JAL    = 9'b0_0100_0000;
   localparam logic [8:0] C_JALR   = 9'b0_0010_0000;
   localparam logic [8:0] C_BRANCH = 9'b0_0001_0000;
   localparam logic [8:0] C_LOAD   = 9'b0_0000_1000;
   localparam logic [8:0] C_STORE  = 9'b0_0000_0100;
   localparam logic [8:0] C_OPIMM  = 9'b0_0000_0010;
   localparam logic [8:0] C_OP     = 9'b0_0000_0001;

`ifdef RV32M_EN
   localparam logic M_ON = 1'b1;
`else
   localparam logic M_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        dec_enabled;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr_raw;
   logic        dec_completed;
   instructions dec_instr;
   logic [4:0]  dec_rs1, dec_rs2;
   logic        exe_enabled;
   instructions exe_instr;
   logic [31:0] exe_rs1, exe_rs2;
   logic        exe_completed;
   instructions exe_instr_out;
   logic [31:0] exe_rs1_out, exe_rs2_out, exe_rd, exe_jump_dest;
   logic        exe_br_taken;

   always #5 clk = ~clk;

   decode_execute dut (
      .clk           (clk),
      .rstn          (rstn),
      .dec_enabled   (dec_enabled),
      .dec_pc        (dec_pc),
      .dec_instr_raw (dec_instr_raw),
      .dec_completed (dec_completed),
      .dec_instr     (dec_instr),
      .dec_rs1       (dec_rs1),
      .dec_rs2       (dec_rs2),
      .exe_enabled   (exe_enabled),
      .exe_instr     (exe_instr),
      .exe_rs1       (exe_rs1),
      .exe_rs2       (exe_rs2),
      .exe_completed (exe_completed),
      .exe_instr_out (exe_instr_out),
      .exe_rs1_out   (exe_rs1_out),
      .exe_rs2_out   (exe_rs2_out),
      .exe_rd        (exe_rd),
      .exe_br_taken  (exe_br_taken),
      .exe_jump_dest (exe_jump_dest)
   );

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        chk_imm;
      logic [8:0]  cls;
      logic        ill;
   } dec_exp_t;

   typedef struct {
      int          id;
      logic [31:0] pc, rs1, rs2, rd, dest;
      logic        taken, chk_dest;
   } exe_exp_t;

   dec_exp_t dec_sb[$];
   exe_exp_t exe_sb[$];
   dec_exp_t de;
   exe_exp_t ee;
   int checks = 0;
   int errors = 0;
   logic dec_fire = 1'b0;
   logic exe_fire = 1'b0;

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d actual %h required %h", name, id, act, exp);
      end
   endtask

   function automatic instructions rec(input logic [8:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] pc, input logic [31:0] imm, input logic ill);
      instructions r;
      r = '0;
      {r.lui, r.auipc, r.jal, r.jalr, r.branch, r.load, r.store, r.op_imm, r.op} = cls;
      r.funct3  = f3;
      r.funct7  = f7;
      r.pc      = pc;
      r.imm     = imm;
      r.illegal = ill;
      return r;
   endfunction

   task automatic dec_tx(input int id, input logic [31:0] raw, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic chk_imm, input logic [8:0] cls, input logic ill);
      dec_exp_t e;
      e.id = id; e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      e.imm = imm; e.chk_imm = chk_imm; e.cls = cls; e.ill = ill;
      dec_sb.push_back(e);
      @(posedge clk); #1;
      dec_enabled   = 1'b1;
      dec_pc        = pc;
      dec_instr_raw = raw;
      @(posedge clk); #1;
      dec_enabled   = 1'b0;
      dec_instr_raw = 32'h0;
   endtask

   task automatic exe_tx(input int id, input instructions r, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] rd, input logic taken, input logic [31:0] dest, input logic chk_dest);
      exe_exp_t e;
      e.id = id; e.pc = r.pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.taken = taken; e.dest = dest; e.chk_dest = chk_dest;
      exe_sb.push_back(e);
      @(posedge clk); #1;
      exe_enabled = 1'b1;
      exe_instr   = r;
      exe_rs1     = rs1;
      exe_rs2     = rs2;
      @(posedge clk); #1;
      exe_enabled = 1'b0;
      exe_instr   = '0;
   endtask

   // A transaction is presented on the cycle after an edge that sampled enable outside reset.
   always @(posedge clk) begin
      dec_fire <= dec_enabled & rstn;
      exe_fire <= exe_enabled & rstn;
   end

   always @(negedge clk) begin
      if (dec_fire) begin
         if (dec_sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL dec_unexpected actual output required none");
         end else begin
            de = dec_sb.pop_front();
            check("dec_completed", de.id, {31'b0, dec_completed}, 32'd1);
            check("dec_rd", de.id, {27'b0, dec_instr.rd}, {27'b0, de.rd});
            check("dec_rs1", de.id, {27'b0, dec_rs1}, {27'b0, de.rs1});
            check("dec_rs2", de.id, {27'b0, dec_rs2}, {27'b0, de.rs2});
            check("dec_rec_rs1", de.id, {27'b0, dec_instr.rs1}, {27'b0, de.rs1});
            check("dec_pc", de.id, dec_instr.pc, de.pc);
            check("dec_illegal", de.id, {31'b0, dec_instr.illegal}, {31'b0, de.ill});
            if (!de.ill)
               check("dec_class", de.id,
                     {23'b0, dec_instr.lui, dec_instr.auipc, dec_instr.jal, dec_instr.jalr, dec_instr.branch,
                      dec_instr.load, dec_instr.store, dec_instr.op_imm, dec_instr.op}, {23'b0, de.cls});
            if (de.chk_imm)
               check("dec_imm", de.id, dec_instr.imm, de.imm);
            $display("dec #%0d rd=%0d rs1=%0d rs2=%0d imm=%h illegal=%0b", de.id, dec_instr.rd,
                     dec_rs1, dec_rs2, dec_instr.imm, dec_instr.illegal);
         end
      end
      if (exe_fire) begin
         if (exe_sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL exe_unexpected actual output required none");
         end else begin
            ee = exe_sb.pop_front();
            check("exe_completed", ee.id, {31'b0, exe_completed}, 32'd1);
            check("exe_rd", ee.id, exe_rd, ee.rd);
            check("exe_taken", ee.id, {31'b0, exe_br_taken}, {31'b0, ee.taken});
            if (ee.chk_dest)
               check("exe_dest", ee.id, exe_jump_dest, ee.dest);
            check("exe_rs1_out", ee.id, exe_rs1_out, ee.rs1);
            check("exe_rs2_out", ee.id, exe_rs2_out, ee.rs2);
            check("exe_pc_out", ee.id, exe_instr_out.pc, ee.pc);
            $display("exe #%0d rd=%h taken=%0b dest=%h", ee.id, exe_rd, exe_br_taken, exe_jump_dest);
         end
      end
   end

   initial begin
      rstn = 1'b0; dec_enabled = 1'b0; exe_enabled = 1'b0;
      dec_pc = '0; dec_instr_raw = '0; exe_instr = '0; exe_rs1 = '0; exe_rs2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dec_completed", 0, {31'b0, dec_completed}, 32'd0);
      check("rst_exe_completed", 0, {31'b0, exe_completed}, 32'd0);
      check("rst_exe_rd", 0, exe_rd, 32'd0);
      check("rst_dec_rs1", 0, {27'b0, dec_rs1}, 32'd0);
      check("rst_exe_taken", 0, {31'b0, exe_br_taken}, 32'd0);
      rstn = 1'b1;

      // Decode vectors
      fork
         dec_tx(1, 32'h002181B3, 32'h0, 5'd3, 5'd3, 5'd2, 32'h0, 1'b0, C_OP, 1'b0);
         exe_tx(1, rec(C_OP, 3'b000, 7'h00, 32'h0, 32'h0, 1'b0), 32'd1, 32'd2, 32'd3, 1'b0, 32'h0, 1'b0);
      join
      dec_tx(2, 32'h002182B3, 32'h4, 5'd5, 5'd3, 5'd2, 32'h0, 1'b0, C_OP, 1'b0);
      dec_tx(3, 32'hFFF00093, 32'h8, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, C_OPIMM, 1'b0);
      dec_tx(4, 32'h00208463, 32'h10, 5'd8, 5'd1, 5'd2, 32'h8, 1'b1, C_BRANCH, 1'b0);
      dec_tx(5, 32'h100000EF, 32'h20, 5'd1, 5'd0, 5'd0, 32'h100, 1'b1, C_JAL, 1'b0);
      dec_tx(6, 32'hFE20AE23, 32'h24, 5'd28, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, C_STORE, 1'b0);
      dec_tx(7, 32'h40405093, 32'h28, 5'd1, 5'd0, 5'd4, 32'h404, 1'b1, C_OPIMM, 1'b0);
      dec_tx(8, 32'hFFFFFFFF, 32'h2C, 5'd31, 5'd31, 5'd31, 32'h0, 1'b0, 9'b0, 1'b1);
      dec_tx(9, 32'h40209133, 32'h30, 5'd2, 5'd1, 5'd2, 32'h0, 1'b0, C_OP, 1'b1);
      dec_tx(10, 32'h022081B3, 32'h34, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, C_OP, !M_ON);
      dec_tx(11, 32'h123450B7, 32'h38, 5'd1, 5'd8, 5'd3, 32'h12345000, 1'b1, C_LUI, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("dec_hold_completed", 11, {31'b0, dec_completed}, 32'd1);
      check("dec_hold_imm", 11, dec_instr.imm, 32'h12345000);

      // Execute vectors
      exe_tx(2, rec(C_OP, 3'b000, 7'h20, 32'h0, 32'h0, 1'b0), 32'd1, 32'd2, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      exe_tx(3, rec(C_OPIMM, 3'b000, 7'h7F, 32'h8, 32'hFFFFFFFF, 1'b0), 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      exe_tx(4, rec(C_BRANCH, 3'b000, 7'h00, 32'h10, 32'h8, 1'b0), 32'd5, 32'd5, 32'h0, 1'b1, 32'h18, 1'b1);
      exe_tx(5, rec(C_BRANCH, 3'b000, 7'h00, 32'h10, 32'h8, 1'b0), 32'd5, 32'd6, 32'h0, 1'b0, 32'h0, 1'b0);
      exe_tx(6, rec(C_OP, 3'b101, 7'h20, 32'h0, 32'h0, 1'b0), 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 32'h0, 1'b0);
      exe_tx(7, rec(C_OP, 3'b101, 7'h00, 32'h0, 32'h0, 1'b0), 32'h80000000, 32'd4, 32'h08000000, 1'b0, 32'h0, 1'b0);
      exe_tx(8, rec(C_OPIMM, 3'b101, 7'h20, 32'h0, 32'h404, 1'b0), 32'h80000000, 32'd0, 32'hF8000000, 1'b0, 32'h0, 1'b0);
      exe_tx(9, rec(C_JAL, 3'b000, 7'h00, 32'h20, 32'h100, 1'b0), 32'd0, 32'd0, 32'h24, 1'b1, 32'h120, 1'b1);
      exe_tx(10, rec(C_JALR, 3'b000, 7'h00, 32'h40, 32'h5, 1'b0), 32'h100, 32'd0, 32'h44, 1'b1, 32'h104, 1'b1);
      exe_tx(11, rec(C_OP, 3'b010, 7'h00, 32'h0, 32'h0, 1'b0), 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 32'h0, 1'b0);
      exe_tx(12, rec(C_OP, 3'b011, 7'h00, 32'h0, 32'h0, 1'b0), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'h0, 1'b0);
      exe_tx(13, rec(C_LUI, 3'b000, 7'h00, 32'h0, 32'h12345000, 1'b0), 32'd9, 32'd9, 32'h12345000, 1'b0, 32'h0, 1'b0);
      exe_tx(14, rec(C_AUIPC, 3'b000, 7'h00, 32'h1000, 32'h2000, 1'b0), 32'd0, 32'd0, 32'h3000, 1'b0, 32'h0, 1'b0);
      exe_tx(15, rec(C_BRANCH, 3'b110, 7'h00, 32'h10, 32'hFFFFFFF8, 1'b0), 32'd1, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h8, 1'b1);
      exe_tx(16, rec(C_BRANCH, 3'b101, 7'h00, 32'h10, 32'h8, 1'b0), 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 32'h0, 1'b0);
      exe_tx(17, rec(C_LOAD, 3'b010, 7'h00, 32'h0, 32'hFFFFFFFC, 1'b0), 32'h100, 32'd0, 32'hFC, 1'b0, 32'h0, 1'b0);
      exe_tx(18, rec(C_OP, 3'b001, 7'h20, 32'h0, 32'h0, 1'b1), 32'd3, 32'd4, 32'h0, 1'b0, 32'h0, 1'b0);
      exe_tx(19, rec(C_OP, 3'b100, 7'h00, 32'h0, 32'h0, 1'b0), 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 32'h0, 1'b0);
      exe_tx(20, rec(C_OPIMM, 3'b001, 7'h00, 32'h0, 32'h4, 1'b0), 32'd1, 32'd0, 32'h10, 1'b0, 32'h0, 1'b0);

      // Reset while both halves hold completed results
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_dec_completed", 0, {31'b0, dec_completed}, 32'd0);
      check("mid_rst_exe_completed", 0, {31'b0, exe_completed}, 32'd0);
      check("mid_rst_exe_rd", 0, exe_rd, 32'd0);
      check("mid_rst_dec_rd", 0, {27'b0, dec_instr.rd}, 32'd0);

      // Reset beats a simultaneous enable
      dec_enabled   = 1'b1;
      dec_instr_raw = 32'h002181B3;
      exe_enabled   = 1'b1;
      exe_instr     = rec(C_OP, 3'b000, 7'h00, 32'h0, 32'h0, 1'b0);
      exe_rs1       = 32'd1;
      exe_rs2       = 32'd2;
      @(posedge clk); #1;
      check("rst_prio_dec_completed", 0, {31'b0, dec_completed}, 32'd0);
      check("rst_prio_exe_completed", 0, {31'b0, exe_completed}, 32'd0);
      check("rst_prio_exe_rd", 0, exe_rd, 32'd0);
      dec_enabled = 1'b0;
      exe_enabled = 1'b0;
      rstn        = 1'b1;

      // Multiply subset: results with RV32M_EN, illegal records otherwise
      exe_tx(21, rec(C_OP, 3'b000, 7'h01, 32'h0, 32'h0, !M_ON), 32'h7FFFFFFF, 32'd2,
             M_ON ? 32'hFFFFFFFE : 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef RV32M_EN
      exe_tx(22, rec(C_OP, 3'b001, 7'h01, 32'h0, 32'h0, 1'b0), 32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      exe_tx(23, rec(C_OP, 3'b010, 7'h01, 32'h0, 32'h0, 1'b0), 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      exe_tx(24, rec(C_OP, 3'b011, 7'h01, 32'h0, 32'h0, 1'b0), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0);
`endif

      for (int i = 0; i < 20 && (dec_sb.size() != 0 || exe_sb.size() != 0); i++)
         @(posedge clk);
      @(negedge clk);
      check("dec_queue_drained", 0, dec_sb.size(), 32'd0);
      check("exe_queue_drained", 0, exe_sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
